mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Sequencer for the MAR and the external memory strobes. Arbitrates between the instruction-fetch requester (PC path) and the operand requester (MBR path). Steers the selected address onto the MAR load buses, then gates C0 and read/write strobes until the memory acknowledges. Runs the two-beat STOREH sequence using the MAR increment control.

Parameters:
ADDR_W, 8, address width; must match MAR width
TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for i_mem_ready before abort (>=1)
STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before fetch is forced

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_fetch_req  in  1  fetch request; level, held until o_fetch_gnt
i_pc_addr  in  ADDR_W  fetch address, sampled on grant
i_data_req  in  1  operand request; level, held until o_data_gnt
i_data_addr  in  ADDR_W  operand address, sampled on grant
i_data_we  in  1  1=write, 0=read; sampled on grant
i_data_double  in  1  two-beat access (STOREH); sampled on grant
i_mem_ready  in  1  memory beat acknowledge
o_pc_mar  out  ADDR_W  PC-side MAR load bus; 0 when not loading
o_mbr_mar  out  ADDR_W  MBR-side MAR load bus; 0 when not loading
o_ctrl_mar_increment  out  1  MAR increment strobe
o_c0  out  1  MAR output enable onto address bus
o_mem_rd  out  1  memory read strobe
o_mem_wr  out  1  memory write strobe
o_fetch_gnt  out  1  1-cycle grant pulse to fetch requester
o_data_gnt  out  1  1-cycle grant pulse to data requester
o_fetch_done  out  1  1-cycle completion pulse, fetch
o_data_done  out  1  1-cycle completion pulse, data
o_err  out  1  1-cycle pulse: timeout or zero-address reject
o_busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. On reset, every output is 0, the FSM is in IDLE, and the starve counter and timeout counter are 0. Reset asserted mid-access aborts immediately with no done or err pulse.
- FSM states: IDLE, LOAD, ACCESS, INCR, DONE.
- IDLE arbitration, evaluated on each edge:
  - Data wins when both requests are present.
  - Exception: fetch wins when starve_cnt == STARVE_LIMIT.
  - starve_cnt increments on each data grant made while i_fetch_req=1, saturating at STARVE_LIMIT. It clears on any fetch grant.
  - A winning request latches its address, we and double into internal registers. The grant pulse is asserted during the following LOAD cycle.
- Zero-address reject: MAR cannot load 0x00, because it treats a zero bus value as "no load". A granted address of 0 therefore gives gnt plus o_err in the same cycle, then returns to IDLE. No memory strobes, no done pulse.
- LOAD (1 cycle):
  - The latched address is driven on o_pc_mar (fetch) or o_mbr_mar (data). The other bus is 0.
  - MAR captures on the closing edge.
  - o_c0, strobes and increment are all 0.
- ACCESS:
  - o_c0=1. o_mem_rd=1 for fetch or data read; o_mem_wr=1 for data write. Load buses are 0.
  - When i_mem_ready=1 at an edge, the beat completes:
    - If double and this is beat 0, go to INCR.
    - Otherwise go to DONE.
  - The timeout counter clears on entry to ACCESS. If it reaches TIMEOUT_CYCLES without ready, pulse o_err and go to IDLE; no done pulse.
- INCR (1 cycle): o_ctrl_mar_increment=1, everything else 0, then go to ACCESS for beat 1.
  - Address wrap is permitted: 0xFF+1 gives beat 1 at 0x00, with no error.
- DONE (1 cycle): the owner's done pulse is asserted, then go to IDLE. A new grant can therefore occur at the earliest on the edge after DONE.
- Latency with ready already high: single beat completes in 3 cycles (LOAD, ACCESS, DONE). Double beat completes in 5 cycles (LOAD, ACCESS, INCR, ACCESS, DONE).
- Fixed invariants:
  - At most one of rd/wr is asserted.
  - C0 is never asserted in the same cycle as a load bus or increment.
  - Requests that drop before grant are ignored. Request changes after grant have no effect.
- i_data_double applies only to data accesses; it is ignored for fetch.

Test Plan:
- Single fetch: i_fetch_req=1, i_pc_addr=0x12, ready tied 1 -> gnt in LOAD with o_pc_mar=0x12; 1 cycle of c0=1, rd=1; o_fetch_done 3 cycles after grant edge.
- STOREH: data_req, addr=0x40, we=1, double=1, ready=1 -> sequence LOAD(o_mbr_mar=0x40), ACCESS(wr), INCR(increment=1), ACCESS(wr), DONE; o_data_done once.
- Contention/starvation: both requests held continuously, STARVE_LIMIT=4 -> 4 data grants then 1 fetch grant; the pattern repeats.
- Timeout: read at 0x05 with ready held 0 -> exactly 16 ACCESS cycles, then o_err pulse, return to IDLE, no done, busy drops.
- Zero address: data_req with addr=0x00 -> o_data_gnt and o_err in the same cycle, no rd/wr/c0, back to IDLE.
- Reset and wrap: double write at 0xFF, ready=1, checks that increment occurs and the second beat completes. Separately, assert i_rst_n=0 during ACCESS -> all outputs go to 0 asynchronously, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MAR / memory-strobe sequencer: arbitrates fetch vs operand requests, loads the MAR,
// then gates C0 and rd/wr until the memory acknowledges; handles two-beat STOREH via MAR increment.
module mem_access_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_pc_addr,
  input  logic              i_data_req,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic              i_data_we,
  input  logic              i_data_double,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_pc_mar,
  output logic [ADDR_W-1:0] o_mbr_mar,
  output logic              o_ctrl_mar_increment,
  output logic              o_c0,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic              o_fetch_gnt,
  output logic              o_data_gnt,
  output logic              o_fetch_done,
  output logic              o_data_done,
  output logic              o_err,
  output logic              o_busy
);

  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACCESS,
    S_INCR,
    S_DONE
  } state_t;

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            is_data;
  logic            we_q;
  logic            dbl_q;
  logic            beat;
  logic            reject;
  logic            data_wins;

  // Data has priority unless a pending fetch has been passed over STARVE_LIMIT times.
  assign data_wins = i_data_req && !(i_fetch_req && (starve_cnt == STARVE_MAX));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                <= S_IDLE;
      starve_cnt           <= '0;
      tmo_cnt              <= '0;
      is_data              <= 1'b0;
      we_q                 <= 1'b0;
      dbl_q                <= 1'b0;
      beat                 <= 1'b0;
      reject               <= 1'b0;
      o_pc_mar             <= '0;
      o_mbr_mar            <= '0;
      o_ctrl_mar_increment <= 1'b0;
      o_c0                 <= 1'b0;
      o_mem_rd             <= 1'b0;
      o_mem_wr             <= 1'b0;
      o_fetch_gnt          <= 1'b0;
      o_data_gnt           <= 1'b0;
      o_fetch_done         <= 1'b0;
      o_data_done          <= 1'b0;
      o_err                <= 1'b0;
      o_busy               <= 1'b0;
    end else begin
      o_pc_mar             <= '0;
      o_mbr_mar            <= '0;
      o_ctrl_mar_increment <= 1'b0;
      o_c0                 <= 1'b0;
      o_mem_rd             <= 1'b0;
      o_mem_wr             <= 1'b0;
      o_fetch_gnt          <= 1'b0;
      o_data_gnt           <= 1'b0;
      o_fetch_done         <= 1'b0;
      o_data_done          <= 1'b0;
      o_err                <= 1'b0;
      case (state)
        S_IDLE: begin
          if (data_wins) begin
            state      <= S_LOAD;
            o_busy     <= 1'b1;
            is_data    <= 1'b1;
            we_q       <= i_data_we;
            dbl_q      <= i_data_double;
            beat       <= 1'b0;
            reject     <= (i_data_addr == '0);
            o_data_gnt <= 1'b1;
            o_mbr_mar  <= i_data_addr;
            o_err      <= (i_data_addr == '0);
            if (i_fetch_req && (starve_cnt != STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (i_fetch_req) begin
            state       <= S_LOAD;
            o_busy      <= 1'b1;
            is_data     <= 1'b0;
            we_q        <= 1'b0;
            dbl_q       <= 1'b0;
            beat        <= 1'b0;
            reject      <= (i_pc_addr == '0);
            o_fetch_gnt <= 1'b1;
            o_pc_mar    <= i_pc_addr;
            o_err       <= (i_pc_addr == '0);
            starve_cnt  <= '0;
          end
        end
        S_LOAD: begin
          // A zero address never reached the MAR, so the grant cycle doubles as the abort.
          if (reject) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else begin
            state    <= S_ACCESS;
            tmo_cnt  <= '0;
            o_c0     <= 1'b1;
            o_mem_rd <= !we_q;
            o_mem_wr <= we_q;
          end
        end
        S_ACCESS: begin
          if (i_mem_ready) begin
            if (dbl_q && !beat) begin
              state                <= S_INCR;
              beat                 <= 1'b1;
              o_ctrl_mar_increment <= 1'b1;
            end else begin
              state        <= S_DONE;
              o_fetch_done <= !is_data;
              o_data_done  <= is_data;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
            o_err  <= 1'b1;
          end else begin
            tmo_cnt  <= tmo_cnt + 1'b1;
            o_c0     <= 1'b1;
            o_mem_rd <= !we_q;
            o_mem_wr <= we_q;
          end
        end
        S_INCR: begin
          state    <= S_ACCESS;
          tmo_cnt  <= '0;
          o_c0     <= 1'b1;
          o_mem_rd <= !we_q;
          o_mem_wr <= we_q;
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
